// File: rtl/payload_engine_pkg.sv
// Shared types and default sizing for the payload engine sequencer.
// The result struct is sized to the package defaults used by payload_engine_ctrl.
package payload_engine_pkg;

    localparam int NUM_ENG_DEF  = 64;
    localparam int PIPE_LAT_DEF = 2;
    localparam int LEN_W_DEF    = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic [NUM_ENG_DEF-1:0] match;
        logic                   any;
        logic [LEN_W_DEF-1:0]   len;
        logic                   trunc;
    } res_t;

endpackage

// File: rtl/payload_ctrl_len_cnt.sv
// Saturating packet byte counter with synchronous clear and a scan-limit flag.
// Latency: count updates on the edge after inc/clr; at_max is combinational from the count.
// Backpressure: none; the caller gates inc with the byte handshake.
module payload_ctrl_len_cnt #(
    parameter int LEN_W   = 11,
    parameter int MAX_LEN = 1518
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [LEN_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [LEN_W-1:0] MAX_CMP = LEN_W'(MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt >= MAX_CMP);

endmodule

// File: rtl/payload_engine_ctrl.sv
// Payload engine sequencer: clear engines per packet, stream bytes, drain, report sticky matches.
// Latency: byte at t drives eng_char/eng_en at t+1; eop at t gives res_valid at t+2+PIPE_LAT.
// Backpressure: s_ready low outside IDLE/SCAN; result held until res_ready. Option: PAYLOAD_CTRL_MAXLEN_EN.
module payload_engine_ctrl
    import payload_engine_pkg::*;
#(
    parameter int NUM_ENG  = NUM_ENG_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int MAX_LEN  = 1518
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic               s_ready,
    output logic [7:0]         eng_char,
    output logic               eng_en,
    output logic               eng_kill,
    output logic               eng_sod,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NUM_ENG-1:0] res_match,
    output logic               res_any,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_trunc,
    output logic               busy
);

    localparam int DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT);

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic             sod_q;
    logic             trunc_q;
    logic             res_vld_q;
    logic             eng_en_q;
    logic             eng_kill_q;
    logic [7:0]       eng_char_q;
    res_t             res_q;
    logic             accept;
    logic             scan_acc;
    logic             fwd;
    logic             drop;
    logic [LEN_W-1:0] len_cnt;
    logic             len_at_max;

    // Gated by rst_n so nothing is handshaked while the block is held in reset.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: s_ready = s_valid & ~s_sop;
                ST_SCAN: s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign accept   = s_valid & s_ready;
    assign scan_acc = accept & (state == ST_SCAN);

`ifdef PAYLOAD_CTRL_MAXLEN_EN
    assign fwd  = scan_acc & ~len_at_max;
    assign drop = scan_acc & len_at_max;
`else
    assign fwd  = scan_acc;
    assign drop = 1'b0;
    logic unused_len_at_max;
    assign unused_len_at_max = len_at_max;
`endif

    payload_ctrl_len_cnt #(
        .LEN_W   (LEN_W),
        .MAX_LEN (MAX_LEN)
    ) u_len_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_CLEAR),
        .inc    (scan_acc),
        .cnt    (len_cnt),
        .at_max (len_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_cnt  <= '0;
            sod_q      <= 1'b0;
            trunc_q    <= 1'b0;
            res_vld_q  <= 1'b0;
            eng_en_q   <= 1'b0;
            eng_kill_q <= 1'b0;
            eng_char_q <= '0;
            res_q      <= '0;
        end else begin
            sod_q      <= 1'b0;
            eng_en_q   <= 1'b0;
            eng_kill_q <= 1'b0;
            if (fwd) begin
                eng_char_q <= s_data;
            end
            case (state)
                ST_IDLE: begin
                    if (s_valid && s_sop) begin
                        state <= ST_CLEAR;
                    end
                end
                // sod lands in the first SCAN cycle, right before the first enabled byte.
                ST_CLEAR: begin
                    sod_q   <= 1'b1;
                    trunc_q <= 1'b0;
                    state   <= ST_SCAN;
                end
                ST_SCAN: begin
                    eng_en_q <= fwd;
                    if (drop) begin
                        trunc_q <= 1'b1;
                    end
                    if (scan_acc && s_eop) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end
                end
                // PIPE_LAT kill cycles flush the chain; end states are sampled on the way out.
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        res_q.match <= eng_match;
                        res_q.any   <= |eng_match;
                        res_q.len   <= len_cnt;
                        res_q.trunc <= trunc_q;
                        res_vld_q   <= 1'b1;
                        state       <= ST_REPORT;
                    end else begin
                        drain_cnt  <= drain_cnt + 1'b1;
                        eng_en_q   <= 1'b1;
                        eng_kill_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_vld_q <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign eng_char  = eng_char_q;
    assign eng_en    = eng_en_q;
    assign eng_kill  = eng_kill_q;
    assign eng_sod   = ~rst_n | sod_q;
    assign res_valid = res_vld_q;
    assign res_match = res_q.match;
    assign res_any   = res_q.any;
    assign res_len   = res_q.len;
    assign res_trunc = res_q.trunc;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Bench for payload_engine_ctrl: vector table of packets plus reset, hold and stray-byte sequences.
module tb_payload_engine_ctrl;

    localparam int NUM_ENG = 64;
    localparam int LEN_W   = 11;
`ifdef PAYLOAD_CTRL_MAXLEN_EN
    localparam bit MAXLEN_ON = 1'b1;
`else
    localparam bit MAXLEN_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         s_data;
    logic               s_valid, s_sop, s_eop, s_ready;
    logic [7:0]         eng_char;
    logic               eng_en, eng_kill, eng_sod;
    logic [NUM_ENG-1:0] eng_match;
    logic               res_valid, res_ready;
    logic [NUM_ENG-1:0] res_match;
    logic               res_any;
    logic [LEN_W-1:0]   res_len;
    logic               res_trunc, busy;

    always #5 clk = ~clk;

    payload_engine_ctrl #(
        .NUM_ENG (NUM_ENG), .PIPE_LAT (2), .LEN_W (LEN_W), .MAX_LEN (4)
    ) dut (
        .clk (clk), .rst_n (rst_n), .s_data (s_data), .s_valid (s_valid),
        .s_sop (s_sop), .s_eop (s_eop), .s_ready (s_ready), .eng_char (eng_char),
        .eng_en (eng_en), .eng_kill (eng_kill), .eng_sod (eng_sod),
        .eng_match (eng_match), .res_valid (res_valid), .res_ready (res_ready),
        .res_match (res_match), .res_any (res_any), .res_len (res_len),
        .res_trunc (res_trunc), .busy (busy)
    );

    typedef struct packed {
        logic [63:0] match;
        logic        any;
        logic [10:0] len;
        logic        trunc;
    } rec_t;

    typedef struct packed {
        int          nbytes;
        logic [47:0] bytes;
        logic [63:0] exp_match;
        int          exp_len;
        int          en_off;
        int          en_on;
        logic        trunc_on;
    } vec_t;

    // Engine model and monitors: sticky match bits, enable/kill counters, event cycles.
    int   cyc = 0;
    int   en_cnt = 0, kill_cnt = 0, en_sum = 0;
    int   eop_cyc = 0, rise_cyc = 0, sod_cyc = 0, first_en_cyc = 0, since_sod = 0;
    logic prev_vld = 1'b0;
    rec_t res_fifo[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_vld <= res_valid;
        if (eng_sod) begin
            eng_match <= '0;
            since_sod <= 0;
            if (rst_n) sod_cyc <= cyc;
        end else if (eng_en && !eng_kill) begin
            if (eng_char == 8'h63) eng_match[5] <= 1'b1;
            if (eng_char == 8'h7a) eng_match[40] <= 1'b1;
        end
        if (eng_en && !eng_kill) begin
            en_cnt <= en_cnt + 1;
            en_sum <= en_sum + int'(eng_char);
            if (!eng_sod) begin
                since_sod <= since_sod + 1;
                if (since_sod == 0) first_en_cyc <= cyc;
            end
        end
        if (eng_en && eng_kill) kill_cnt <= kill_cnt + 1;
        if (s_valid && s_ready && s_eop) eop_cyc <= cyc;
        if (res_valid && !prev_vld) rise_cyc <= cyc;
        if (res_valid && res_ready) res_fifo.push_back('{res_match, res_any, res_len, res_trunc});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
        int  n;
        bit  acc;
        n = 0;
        s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
        forever begin
            #1;
            acc = s_ready;
            @(negedge clk);
            if (acc) break;
            if (++n > 50) begin
                timeout("send_byte");
                break;
            end
        end
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic get_result(input string name, output rec_t r, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        r  = '0;
        while (res_fifo.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (res_fifo.size() == 0) begin
            timeout(name);
        end else begin
            r  = res_fifo.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic check_pkt(input string name, input int exp_len, input logic [63:0] exp_match,
                             input logic exp_trunc);
        rec_t r;
        bit   ok;
        get_result(name, r, ok);
        if (ok) begin
            check({name, "_len"}, 64'(r.len), 64'(exp_len));
            check({name, "_match"}, r.match, exp_match);
            check({name, "_any"}, 64'(r.any), 64'(|exp_match));
            check({name, "_trunc"}, 64'(r.trunc), 64'(exp_trunc));
        end
    endtask

    vec_t vec [5];

    initial begin
        int   en0, kill0, sum0, exp_sum, exp_en, hs, nq;
        bit   ok;

        vec[0] = '{3, 48'h000000_636261, 64'h20, 3, 3, 3, 1'b0};
        vec[1] = '{1, 48'h000000_000041, 64'h0, 1, 1, 1, 1'b0};
        vec[2] = '{5, 48'h0010_63ff_007a, 64'h0000_0100_0000_0020, 5, 5, 4, 1'b1};
        vec[3] = '{6, 48'h0605_0403_0201, 64'h0, 6, 6, 4, 1'b1};
        vec[4] = '{4, 48'h0000_6163_637a, 64'h0000_0100_0000_0020, 4, 4, 4, 1'b0};

        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        res_ready = 1'b1;
        #1;
        check("rst_sod", 64'(eng_sod), 64'd1);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_en", 64'(eng_en), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_sod", 64'(eng_sod), 64'd0);
        @(negedge clk);

        // Table of whole packets with sop on the first byte and eop on the last.
        for (int i = 0; i < 5; i++) begin
            en0 = en_cnt; kill0 = kill_cnt; sum0 = en_sum;
            for (int k = 0; k < vec[i].nbytes; k++)
                send_byte(vec[i].bytes[k*8 +: 8], k == 0, k == vec[i].nbytes - 1);
            check_pkt($sformatf("vec%0d", i), vec[i].exp_len, vec[i].exp_match,
                      MAXLEN_ON ? vec[i].trunc_on : 1'b0);
            exp_en  = MAXLEN_ON ? vec[i].en_on : vec[i].en_off;
            exp_sum = 0;
            for (int k = 0; k < exp_en; k++) exp_sum += int'(vec[i].bytes[k*8 +: 8]);
            check($sformatf("vec%0d_en_cycles", i), 64'(en_cnt - en0), 64'(exp_en));
            check($sformatf("vec%0d_kill_cycles", i), 64'(kill_cnt - kill0), 64'd2);
            check($sformatf("vec%0d_char_sum", i), 64'(en_sum - sum0), 64'(exp_sum));
            check($sformatf("vec%0d_valid_lat", i), 64'(rise_cyc - eop_cyc), 64'd4);
            check($sformatf("vec%0d_sod_to_en", i), 64'(first_en_cyc - sod_cyc), 64'd1);
            @(negedge clk);
        end

        // Result held with a second sop waiting.
        res_ready = 1'b0;
        send_byte(8'h63, 1'b1, 1'b1);
        hs = 0;
        while (!res_valid && hs < 40) begin
            @(negedge clk);
            hs++;
        end
        if (!res_valid) timeout("hold_valid");
        s_data = 8'h55; s_sop = 1'b1; s_eop = 1'b1; s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("hold_s_ready", 64'(s_ready), 64'd0);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_len", 64'(res_len), 64'd1);
            check("hold_match", res_match, 64'h20);
            check("hold_sod", 64'(eng_sod), 64'd0);
            @(negedge clk);
        end
        hs = cyc;
        res_ready = 1'b1;
        send_byte(8'h55, 1'b1, 1'b1);
        check_pkt("hold_first", 1, 64'h20, 1'b0);
        check_pkt("hold_second", 1, 64'h0, 1'b0);
        check("hold_sod_cycle", 64'(sod_cyc - hs), 64'd3);
        @(negedge clk);

        // Stray bytes in IDLE, then a packet with a sop in the middle.
        en0 = en_cnt;
        send_byte(8'h63, 1'b0, 1'b0);
        send_byte(8'h7a, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("stray_en", 64'(en_cnt - en0), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_no_result", 64'(res_fifo.size()), 64'd0);
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h42, 1'b1, 1'b0);
        send_byte(8'h43, 1'b0, 1'b1);
        check_pkt("mid_sop", 3, 64'h0, 1'b0);
        check("mid_sop_en", 64'(en_cnt - en0), 64'd3);
        @(negedge clk);

        // Reset in the middle of a packet.
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h62, 1'b0, 1'b0);
        rst_n = 1'b0;
        s_data = 8'h63; s_valid = 1'b1;
        #1;
        check("midrst_sod", 64'(eng_sod), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(s_ready), 64'd0);
        check("midrst_en", 64'(eng_en), 64'd0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h63, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        nq = res_fifo.size();
        check("midrst_no_result", 64'(nq), 64'd0);
        check("midrst_valid", 64'(res_valid), 64'd0);
        send_byte(8'h30, 1'b1, 1'b0);
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b1);
        check_pkt("after_rst", 3, 64'h0, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
